// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, credit-limited IM request channel and prefetch FIFO.
// Define FETCH_PERF_EN to add the perf_fetched / perf_dropped counters.
module fetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        im_req_valid,
    input  logic        im_req_ready,
    output logic [31:0] im_addr,
    input  logic        im_rsp_valid,
    input  logic [31:0] im_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped,
`endif
    output logic [31:0] out_pc_add4
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTST + 1) + 1;

    logic [31:0]   pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [OW-1:0] live;
    logic [OW-1:0] drop;
    logic [OW-1:0] inflight;
    logic          has_entry;
    logic          issue_ok;
    logic          req_fire;
    logic          rsp_keep;
    logic          rsp_drop;
    logic          rsp_any;
    logic          pop;

    // Credit check ignores a same-cycle pop so the FIFO can never be overrun.
    assign inflight  = live + drop;
    assign has_entry = (count != '0);
    assign issue_ok  = (int'(inflight) < int'(MAX_OUTST)) &&
                       (int'(count) + int'(live) < int'(DEPTH));

    assign im_req_valid = rst && !redirect && issue_ok;
    assign im_addr      = pc;
    assign req_fire     = im_req_valid && im_req_ready;

    assign rsp_drop = im_rsp_valid && (drop != '0);
    assign rsp_keep = im_rsp_valid && (drop == '0) && (live != '0);
    assign rsp_any  = im_rsp_valid && (inflight != '0);

    assign out_valid   = has_entry && !redirect;
    assign pop         = out_valid && out_ready;
    assign out_instr   = has_entry ? instr_mem[rd_ptr] : '0;
    assign out_pc      = has_entry ? pc_mem[rd_ptr] : '0;
    assign out_pc_add4 = has_entry ? pc_mem[rd_ptr] + 32'd4 : '0;

    // Redirect outranks everything: responses still in flight become drops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc     <= RESET_PC;
            rsp_pc <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            live   <= '0;
            drop   <= '0;
        end else if (redirect) begin
            pc     <= redirect_pc & ~32'h3;
            rsp_pc <= redirect_pc & ~32'h3;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            live   <= '0;
            drop   <= inflight - OW'(rsp_any);
        end else begin
            if (req_fire) pc <= pc + 32'd4;
            if (rsp_keep) rsp_pc <= rsp_pc + 32'd4;
            wr_ptr <= wr_ptr + PW'(rsp_keep);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(rsp_keep) - CW'(pop);
            live   <= live + OW'(req_fire) - OW'(rsp_keep);
            drop   <= drop - OW'(rsp_drop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !redirect && rsp_keep) begin
            instr_mem[wr_ptr] <= im_rsp_data;
            pc_mem[wr_ptr]    <= rsp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !redirect && rsp_keep) begin
            assert (count != CW'(DEPTH));
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (pop) perf_fetched <= perf_fetched + 32'd1;
            if (redirect ? rsp_any : rsp_drop) perf_dropped <= perf_dropped + 32'd1;
        end
    end
`endif

endmodule
